// File: rtl/yolo_osif_packer.sv
// Result packer: gathers DBITS-wide elements into TBITS-wide osif words.
// Emits one frame of cfg_len elements; the final word carries last and a partial strobe.
module yolo_osif_packer #(
  parameter int TBITS = 64,
  parameter int TBYTE = 8,
  parameter int DBITS = 8,
  parameter int LEN_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DBITS-1:0] in_data,
  output logic             busy,
  output logic             done,
  output logic [TBITS-1:0] osif_data_din,
  output logic [TBYTE-1:0] osif_strb_din,
  output logic             osif_last_din,
  output logic             osif_user_din,
  output logic             osif_write,
  input  logic             osif_full_n
);

  localparam int LANES = TBITS / DBITS;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SPL   = DBITS / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PACK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [LW-1:0]    r_lane;
  logic             r_first;
  logic [TBITS-1:0] r_pack;
  logic [TBITS-1:0] r_out_data;
  logic [TBYTE-1:0] r_out_strb;
  logic             r_out_last;
  logic             r_out_user;
  logic             r_out_valid;

  logic             w_out_free;
  logic             w_complete;
  logic             w_accept;
  logic             w_load;
  logic             w_xfer;
  logic [TBITS-1:0] w_word;
  logic [TBYTE-1:0] w_strb;

  assign w_out_free = !r_out_valid || osif_full_n;
  assign w_complete = (r_lane == LW'(LANES - 1)) ||
                      (r_remaining == LEN_W'(1));
  assign in_ready   = (r_state == S_PACK) &&
                      (r_remaining != '0) &&
                      (!w_complete || w_out_free);
  assign w_accept   = in_valid && in_ready;
  assign w_load     = w_accept && w_complete;
  assign w_xfer     = r_out_valid && osif_full_n;

  // Lanes above the current one stay zero because r_pack is cleared per word.
  always_comb begin
    w_word = r_pack;
    w_word[r_lane*DBITS +: DBITS] = in_data;
    w_strb = '0;
    for (int k = 0; k < LANES; k++) begin
      if (LW'(k) <= r_lane) w_strb[k*SPL +: SPL] = '1;
    end
  end

  assign osif_data_din = r_out_data;
  assign osif_strb_din = r_out_strb;
  assign osif_last_din = r_out_last;
  assign osif_user_din = r_out_user;
  assign osif_write    = r_out_valid;
  assign busy          = (r_state == S_PACK) || (r_state == S_DRAIN);
  assign done          = (r_state == S_DONE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_lane      <= '0;
      r_first     <= 1'b0;
      r_pack      <= '0;
      r_out_data  <= '0;
      r_out_strb  <= '0;
      r_out_last  <= 1'b0;
      r_out_user  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= w_word;
        r_out_strb  <= w_strb;
        r_out_last  <= (r_remaining == LEN_W'(1));
        r_out_user  <= r_first;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_remaining <= cfg_len;
            r_lane      <= '0;
            r_first     <= 1'b1;
            r_pack      <= '0;
            r_state     <= (cfg_len != '0) ? S_PACK : S_DONE;
          end
        end
        S_PACK: begin
          if (w_accept) begin
            r_remaining <= r_remaining - 1'b1;
            if (w_complete) begin
              r_lane  <= '0;
              r_first <= 1'b0;
              r_pack  <= '0;
            end else begin
              r_lane <= r_lane + 1'b1;
              r_pack <= w_word;
            end
            if (r_remaining == LEN_W'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_xfer) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yolo_osif_packer.sv
// Randomised bench for yolo_osif_packer.
// Expected words come from grouping each frame's elements into LANES-wide chunks.
module tb_yolo_osif_packer;

  localparam int LANES = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        busy;
  logic        done;
  logic [63:0] osif_data_din;
  logic [7:0]  osif_strb_din;
  logic        osif_last_din;
  logic        osif_user_din;
  logic        osif_write;
  logic        osif_full_n = 1'b1;

  always #5 aclk = ~aclk;

  yolo_osif_packer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_start     (cfg_start),
    .cfg_len       (cfg_len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .busy          (busy),
    .done          (done),
    .osif_data_din (osif_data_din),
    .osif_strb_din (osif_strb_din),
    .osif_last_din (osif_last_din),
    .osif_user_din (osif_user_din),
    .osif_write    (osif_write),
    .osif_full_n   (osif_full_n)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } word_t;

  word_t      exp_q[$];
  logic [7:0] elems[$];
  int         m_len = 0;
  int         m_left = 0;
  int         n_wr = 0;
  bit         m_active = 0;
  bit         nxt_done = 0;
  bit         got_done = 0;
  bit         prev_stall = 0;
  word_t      pv;

  function automatic void build(int len);
    int nw;
    int i;
    word_t x;
    nw = (len + LANES - 1) / LANES;
    for (int w = 0; w < nw; w++) begin
      x.data = '0;
      x.strb = '0;
      for (int k = 0; k < LANES; k++) begin
        i = w * LANES + k;
        if (i < len) begin
          x.data = x.data | (64'(elems[i]) << (8 * k));
          x.strb[k] = 1'b1;
        end
      end
      x.last = (w == nw - 1);
      x.user = (w == 0);
      exp_q.push_back(x);
    end
  endfunction

  // Called just after a negedge with inputs driven; observes, then waits.
  task automatic tick();
    bit    exp_done;
    bit    was_active;
    bit    compl;
    int    idx;
    word_t e;
    #1;
    exp_done   = nxt_done;
    nxt_done   = 0;
    was_active = m_active;
    chk("done", done, exp_done);
    chk("busy", busy, m_active);
    idx   = m_len - m_left;
    compl = (idx % LANES == LANES - 1) || (m_left == 1);
    chk("in_ready", in_ready,
        m_active && m_left > 0 &&
        (!compl || !osif_write || osif_full_n));
    if (in_valid && in_ready && m_left > 0) m_left--;
    if (prev_stall) begin
      chk("hold_data", osif_data_din, pv.data);
      chk("hold_strb", osif_strb_din, pv.strb);
      chk("hold_last", osif_last_din, pv.last);
      chk("hold_user", osif_user_din, pv.user);
    end
    if (osif_write && osif_full_n) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        chk("extra_write", osif_write, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("data", osif_data_din, e.data);
        chk("strb", osif_strb_din, e.strb);
        chk("last", osif_last_din, e.last);
        chk("user", osif_user_din, e.user);
        if (e.last) begin
          nxt_done = 1;
          m_active = 0;
        end
      end
    end
    prev_stall = osif_write && !osif_full_n;
    pv.data = osif_data_din;
    pv.strb = osif_strb_din;
    pv.last = osif_last_din;
    pv.user = osif_user_din;
    if (exp_done) got_done = 1;
    if (cfg_start && !was_active && !exp_done) begin
      m_len    = int'(cfg_len);
      m_left   = int'(cfg_len);
      n_wr     = 0;
      got_done = 0;
      build(int'(cfg_len));
      if (cfg_len == 0) nxt_done = 1;
      else m_active = 1;
    end
    @(negedge aclk);
  endtask

  task automatic start_frame(int len, int base);
    elems.delete();
    for (int i = 0; i < len; i++)
      elems.push_back(base >= 0 ? 8'(base + i) : 8'($urandom));
    cfg_len     = 16'(len);
    cfg_start   = 1'b1;
    in_valid    = 1'b0;
    osif_full_n = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // mode 0: full_n high; 1: 5-cycle stall at first word; 2: random full_n
  task automatic run_frame(int len, int base, int vpct, int mode, bit mid);
    int stall;
    int cyc;
    bit seen;
    start_frame(len, base);
    stall = 0;
    seen  = 0;
    cyc   = 0;
    while (!got_done && cyc < 3000) begin
      in_valid = ($urandom_range(99) < vpct);
      in_data  = (m_left > 0) ? elems[m_len - m_left] : 8'($urandom);
      if (mode == 1) begin
        if (osif_write && !seen) begin
          seen  = 1;
          stall = 5;
        end
        osif_full_n = (stall == 0);
        if (stall > 0) stall--;
      end else if (mode == 2) begin
        osif_full_n = ($urandom_range(3) != 0);
      end else begin
        osif_full_n = 1'b1;
      end
      cfg_start = mid && m_left > 0 && ($urandom_range(7) == 0);
      cfg_len   = 16'(len + 3);
      tick();
      cyc++;
    end
    cfg_start   = 1'b0;
    in_valid    = 1'b0;
    osif_full_n = 1'b1;
    chk("done_seen", got_done, 1'b1);
    chk("n_writes", n_wr, (len + LANES - 1) / LANES);
    chk("q_empty", exp_q.size(), 0);
  endtask

  task automatic reset_mid_frame();
    start_frame(8, -1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = elems[m_len - m_left];
      tick();
    end
    in_valid = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_write", osif_write, 1'b0);
    chk("rst_data", osif_data_din, 64'h0);
    chk("rst_strb", osif_strb_din, 8'h0);
    chk("rst_last", osif_last_din, 1'b0);
    chk("rst_user", osif_user_din, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", in_ready, 1'b0);
    @(negedge aclk);
    chk("rst_write2", osif_write, 1'b0);
    @(negedge aclk);
    aresetn    = 1'b1;
    m_active   = 0;
    m_left     = 0;
    m_len      = 0;
    nxt_done   = 0;
    prev_stall = 0;
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge aclk);
    chk("init_write", osif_write, 1'b0);
    chk("init_data", osif_data_din, 64'h0);
    chk("init_busy", busy, 1'b0);
    chk("init_done", done, 1'b0);
    chk("init_ready", in_ready, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);

    run_frame(8, 8'h01, 100, 0, 0);
    run_frame(11, 8'h10, 100, 0, 0);
    run_frame(16, -1, 100, 1, 0);
    run_frame(0, -1, 100, 0, 0);
    run_frame(20, -1, 80, 0, 1);
    reset_mid_frame();
    run_frame(8, 8'h21, 100, 0, 0);
    for (int f = 0; f < 25; f++)
      run_frame($urandom_range(40), -1, $urandom_range(30, 100), 2,
                ($urandom_range(1) == 1));
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
